// File: rtl/snn_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : snn_ctrl_pkg
// Brief    : Shared types and constants for the spiking classifier sequencer
//            and its spike-count readout.
// Revision : 1.0  initial release
// ============================================================================
package snn_ctrl_pkg;

  // Default classifier geometry, shared with the spike counter bank.
  localparam int SNN_NUM_CLASSES = 10;
  localparam int SNN_COUNT_W     = 8;

  // Sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_SCAN  = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  // Extract the count of class k from the flattened counter bus.
  function automatic logic [SNN_COUNT_W-1:0] count_at(
    input logic [SNN_NUM_CLASSES*SNN_COUNT_W-1:0] flat,
    input int unsigned                            k
  );
    return flat[k*SNN_COUNT_W +: SNN_COUNT_W];
  endfunction

endpackage
`default_nettype wire

// File: rtl/snn_argmax_scan.sv
`default_nettype none
// ============================================================================
// Module   : snn_argmax_scan
// Brief    : Sequential argmax over a flat bus of counts, one entry per step.
//            Ties keep the lowest index; the result of the current step is
//            available combinationally so the caller can capture it on the
//            final step without an extra cycle.
// Revision : 1.0  initial release
// ============================================================================
module snn_argmax_scan
  import snn_ctrl_pkg::*;
#(
  parameter int NUM_CLASSES = SNN_NUM_CLASSES,
  parameter int COUNT_W     = SNN_COUNT_W
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                start_i,
  input  logic                                step_i,
  input  logic [NUM_CLASSES*COUNT_W-1:0]      counts_i,
  output logic                                last_o,
  output logic [$clog2(NUM_CLASSES)-1:0]      result_idx_o,
  output logic [COUNT_W-1:0]                  result_cnt_o
);

  localparam int IDX_W = $clog2(NUM_CLASSES);

  logic [COUNT_W-1:0] counts_arr [NUM_CLASSES];
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   best_idx;
  logic [COUNT_W-1:0] best_cnt;
  logic [COUNT_W-1:0] cur_cnt;
  logic               take;

  for (genvar k = 0; k < NUM_CLASSES; k++) begin : g_unpack
    assign counts_arr[k] = counts_i[k*COUNT_W +: COUNT_W];
  end

  // Strict compare so an equal later count never displaces an earlier winner.
  always_comb begin
    cur_cnt      = counts_arr[idx];
    take         = step_i && (cur_cnt > best_cnt);
    result_idx_o = take ? idx : best_idx;
    result_cnt_o = take ? cur_cnt : best_cnt;
    last_o       = (idx == IDX_W'(NUM_CLASSES - 1));
  end

  // Index and running best; cleared by start, advanced by step.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idx      <= '0;
      best_idx <= '0;
      best_cnt <= '0;
    end else if (start_i) begin
      idx      <= '0;
      best_idx <= '0;
      best_cnt <= '0;
    end else if (step_i) begin
      best_idx <= result_idx_o;
      best_cnt <= result_cnt_o;
      if (!last_o) begin
        idx <= idx + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/snn_inference_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : snn_inference_ctrl
// Brief    : Inference sequencer for the spiking classifier: clear, present
//            input for a window of timesteps, drain in-flight spikes, scan the
//            per-class spike counts for an argmax and report the winner.
// Revision : 1.0  initial release
// ============================================================================
module snn_inference_ctrl
  import snn_ctrl_pkg::*;
#(
  parameter int NUM_CLASSES  = SNN_NUM_CLASSES,
  parameter int COUNT_W      = SNN_COUNT_W,
  parameter int WINDOW_W     = 8,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            start_i,
  input  logic                            abort_i,
  input  logic [WINDOW_W-1:0]             window_i,
  input  logic [NUM_CLASSES*COUNT_W-1:0]  spike_count_i,
  output logic                            net_clear_o,
  output logic                            net_en_o,
  output logic                            in_valid_o,
  output logic                            busy_o,
  output logic                            done_o,
  output logic [$clog2(NUM_CLASSES)-1:0]  class_o,
  output logic [COUNT_W-1:0]              max_count_o
);

  localparam int CLASS_W = $clog2(NUM_CLASSES);
  // Drain counter must hold DRAIN_CYCLES; keep at least one bit when it is 0.
  localparam int DRAIN_W = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

  state_t               state;
  state_t               state_nxt;
  logic [WINDOW_W-1:0]  run_cnt;
  logic [DRAIN_W-1:0]   drain_cnt;
  logic                 start_ok;
  logic                 scan_last;
  logic [CLASS_W-1:0]   scan_idx;
  logic [COUNT_W-1:0]   scan_cnt;

  assign start_ok = start_i && !abort_i;

  // Every strobe is a pure decode of the state register.
  assign net_clear_o = (state == ST_CLEAR);
  assign net_en_o    = (state == ST_RUN) || (state == ST_DRAIN);
  assign in_valid_o  = (state == ST_RUN);
  assign busy_o      = (state != ST_IDLE);
  assign done_o      = (state == ST_DONE);

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; abort overrides every non-idle transition.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start_ok) state_nxt = ST_CLEAR;
      ST_CLEAR: state_nxt = ST_RUN;
      ST_RUN: begin
        if (run_cnt <= WINDOW_W'(1)) begin
          state_nxt = (DRAIN_CYCLES == 0) ? ST_SCAN : ST_DRAIN;
        end
      end
      ST_DRAIN: if (drain_cnt <= DRAIN_W'(1)) state_nxt = ST_SCAN;
      ST_SCAN:  if (scan_last) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
    if (abort_i && (state != ST_IDLE)) begin
      state_nxt = ST_IDLE;
    end
  end

  // Timestep/drain counters and the result registers loaded on entry to DONE.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      run_cnt     <= '0;
      drain_cnt   <= '0;
      class_o     <= '0;
      max_count_o <= '0;
    end else begin
      if ((state == ST_IDLE) && start_ok) begin
        // A zero window still presents the input for one timestep.
        run_cnt <= (window_i == '0) ? WINDOW_W'(1) : window_i;
      end else if (state == ST_RUN) begin
        run_cnt <= run_cnt - 1'b1;
      end

      if (state == ST_DRAIN) begin
        drain_cnt <= drain_cnt - 1'b1;
      end else begin
        drain_cnt <= DRAIN_W'(DRAIN_CYCLES);
      end

      if ((state == ST_SCAN) && scan_last && !abort_i) begin
        class_o     <= scan_idx;
        max_count_o <= scan_cnt;
      end
    end
  end

  snn_argmax_scan #(
    .NUM_CLASSES (NUM_CLASSES),
    .COUNT_W     (COUNT_W)
  ) u_scan (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_i      (state == ST_CLEAR),
    .step_i       (state == ST_SCAN),
    .counts_i     (spike_count_i),
    .last_o       (scan_last),
    .result_idx_o (scan_idx),
    .result_cnt_o (scan_cnt)
  );

endmodule
`default_nettype wire

// File: tb/tb_snn_inference_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_snn_inference_ctrl
// Brief    : Directed, table-driven bench for the inference sequencer.
// Revision : 1.0  initial release
// ============================================================================
module tb_snn_inference_ctrl;
  import snn_ctrl_pkg::*;

  localparam int NC = 10;
  localparam int CW = 8;
  localparam int WW = 8;
  localparam int DC = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [WW-1:0]    window = '0;
  logic [NC*CW-1:0] counts = '0;
  logic             net_clear, net_en, in_valid, busy, done;
  logic [3:0]       class_id;
  logic [CW-1:0]    max_count;

  int pass_cnt = 0;
  int total_cnt = 0;

  typedef struct {
    int               window;
    logic [NC*CW-1:0] counts;
    int               exp_class;
    int               exp_max;
    int               exp_lat;
    int               exp_en;
    int               exp_val;
  } vec_t;

  vec_t vecs[7];

  always #5 clk = ~clk;

  snn_inference_ctrl #(
    .NUM_CLASSES  (NC),
    .COUNT_W      (CW),
    .WINDOW_W     (WW),
    .DRAIN_CYCLES (DC)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .start_i       (start),
    .abort_i       (abort),
    .window_i      (window),
    .spike_count_i (counts),
    .net_clear_o   (net_clear),
    .net_en_o      (net_en),
    .in_valid_o    (in_valid),
    .busy_o        (busy),
    .done_o        (done),
    .class_o       (class_id),
    .max_count_o   (max_count)
  );

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NC*CW-1:0] pack10(input int c[10]);
    logic [NC*CW-1:0] r;
    r = '0;
    for (int k = 0; k < NC; k++) r[k*CW +: CW] = CW'(c[k]);
    return r;
  endfunction

  // Start one inference and follow it to done_o (bounded).
  task automatic run_vec(input int w, input logic [NC*CW-1:0] cnts,
                         output int lat, output int en, output int val,
                         output int clr);
    counts = cnts;
    window = WW'(w);
    start  = 1'b1;
    tick();
    start  = 1'b0;
    lat = -1; en = 0; val = 0; clr = 0;
    for (int n = 1; n <= 400 && lat < 0; n++) begin
      en  += int'(net_en);
      val += int'(in_valid);
      clr += int'(net_clear);
      if (done) lat = n;
      else tick();
    end
  endtask

  initial begin
    int tmp[10];
    int lat, en, val, clr, ndone, first_done, sbusy;

    tmp = '{3, 7, 1, 0, 7, 2, 0, 0, 5, 6};
    vecs[0] = '{4, pack10(tmp), 1, 7, 18, 6, 4};
    tmp = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[1] = '{0, pack10(tmp), 0, 0, 15, 3, 1};
    tmp = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 255};
    vecs[2] = '{1, pack10(tmp), 9, 255, 15, 3, 1};
    tmp = '{9, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[3] = '{3, pack10(tmp), 0, 9, 17, 5, 3};
    tmp = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
    vecs[4] = '{2, pack10(tmp), 9, 10, 16, 4, 2};
    tmp = '{200, 200, 200, 200, 200, 200, 200, 200, 200, 200};
    vecs[5] = '{5, pack10(tmp), 0, 200, 19, 7, 5};
    tmp = '{0, 0, 0, 0, 0, 0, 0, 0, 4, 4};
    vecs[6] = '{255, pack10(tmp), 8, 4, 269, 257, 255};

    // Reset state
    tick(); tick();
    chk("reset net_clear", int'(net_clear), 0);
    chk("reset net_en", int'(net_en), 0);
    chk("reset in_valid", int'(in_valid), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset class", int'(class_id), 0);
    chk("reset max", int'(max_count), 0);
    rst = 1'b0;
    tick();

    // Table-driven inferences
    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i].window, vecs[i].counts, lat, en, val, clr);
      chk($sformatf("v%0d latency", i), lat, vecs[i].exp_lat);
      chk($sformatf("v%0d class", i), int'(class_id), vecs[i].exp_class);
      chk($sformatf("v%0d max", i), int'(max_count), vecs[i].exp_max);
      chk($sformatf("v%0d net_en cycles", i), en, vecs[i].exp_en);
      chk($sformatf("v%0d in_valid cycles", i), val, vecs[i].exp_val);
      chk($sformatf("v%0d clear cycles", i), clr, 1);
      tick();
      chk($sformatf("v%0d done pulse width", i), int'(done), 0);
      chk($sformatf("v%0d busy after done", i), int'(busy), 0);
    end

    // Asynchronous reset mid-RUN; previous result (class 8) is cleared too
    counts = vecs[0].counts;
    window = 8'd8;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    tick(); tick();
    chk("pre-reset in RUN net_en", int'(net_en), 1);
    #3 rst = 1'b1;
    #1;
    chk("async rst net_en", int'(net_en), 0);
    chk("async rst in_valid", int'(in_valid), 0);
    chk("async rst busy", int'(busy), 0);
    chk("async rst class", int'(class_id), 0);
    chk("async rst max", int'(max_count), 0);
    tick();
    rst = 1'b0;
    ndone = 0; sbusy = 0;
    for (int n = 0; n < 40; n++) begin
      tick();
      ndone += int'(done);
      sbusy += int'(busy);
    end
    chk("post-reset done count", ndone, 0);
    chk("post-reset busy cycles", sbusy, 0);

    // Start while busy: second start during SCAN is ignored
    counts = vecs[0].counts;
    window = 8'd4;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    ndone = 0; first_done = -1;
    for (int n = 1; n <= 60; n++) begin
      if (n == 14) begin
        start  = 1'b1;
        window = 8'd20;
      end else begin
        start  = 1'b0;
      end
      if (done) begin
        ndone++;
        if (first_done < 0) first_done = n;
      end
      tick();
    end
    start = 1'b0;
    chk("busy-start done count", ndone, 1);
    chk("busy-start done cycle", first_done, 18);
    chk("busy-start class", int'(class_id), 1);
    chk("busy-start max", int'(max_count), 7);

    // Abort during DRAIN keeps the previous result
    counts = vecs[2].counts;
    window = 8'd2;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    tick(); tick(); tick();
    chk("drain net_en", int'(net_en), 1);
    chk("drain in_valid", int'(in_valid), 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort busy", int'(busy), 0);
    ndone = 0;
    for (int n = 0; n < 30; n++) begin
      ndone += int'(done);
      tick();
    end
    chk("abort done count", ndone, 0);
    chk("abort class kept", int'(class_id), 1);
    chk("abort max kept", int'(max_count), 7);

    // Abort together with start in IDLE: start dropped
    window = 8'd3;
    start  = 1'b1;
    abort  = 1'b1;
    tick();
    start  = 1'b0;
    abort  = 1'b0;
    sbusy = 0;
    for (int n = 0; n < 5; n++) begin
      sbusy += int'(busy);
      tick();
    end
    chk("abort+start busy cycles", sbusy, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/snn_inference_ctrl.md
# snn_inference_ctrl

Sequencer for the spiking classifier datapath: hidden LIF layer, output LIF layer and spike counter. On a start request it clears neuron membranes and spike counters, presents the input pattern for a programmable window of timesteps, and drains in-flight spikes. It then scans the ten per-class spike counts sequentially for an argmax and reports the winning class with a done pulse. The block sits between the top-level I/O and the network, and is the only driver of the network's clear and enable controls.

## Interface
Parameters:
- NUM_CLASSES, 10, number of output neurons/counters scanned
- COUNT_W, 8, width of each spike count
- WINDOW_W, 8, width of window length input
- DRAIN_CYCLES, 2, extra enabled cycles with input gated off (hidden + output LIF register depth)

Ports:
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  asynchronous, active-high reset
- start_i  in  1  begin inference; sampled only in IDLE
- abort_i  in  1  synchronous abort; highest priority after reset
- window_i  in  WINDOW_W  timesteps to present input; latched on accepted start
- spike_count_i  in  NUM_CLASSES*COUNT_W  flattened counts, class k at bits [k*COUNT_W +: COUNT_W]
- net_clear_o  out  1  one-cycle clear of LIF membranes/thresholds and spike counters
- net_en_o  out  1  network advances one timestep per cycle when high
- in_valid_o  out  1  gate for input pattern (input forced to 0 when low)
- busy_o  out  1  high in every state except IDLE
- done_o  out  1  one-cycle pulse, result valid
- class_o  out  $clog2(NUM_CLASSES)  winning class index, held until next accepted start
- max_count_o  out  COUNT_W  spike count of winning class, held likewise

## Operation
- States: IDLE, CLEAR, RUN, DRAIN, SCAN, DONE.
- IDLE: all strobes low. start_i=1 latches window_i, transitions to CLEAR.
- CLEAR: net_clear_o=1 for exactly one cycle, then RUN.
- RUN: net_en_o=1, in_valid_o=1. Timestep counter runs from latched window down to 1. A latched window of 0 is treated as 1. Transitions to DRAIN after the final cycle.
- DRAIN: net_en_o=1, in_valid_o=0, for DRAIN_CYCLES cycles. DRAIN_CYCLES=0 skips directly to SCAN.
- SCAN: net_en_o=0, so counts are frozen. Index i runs 0..NUM_CLASSES-1, one class per cycle. The running best is replaced only when count[i] > best, so ties resolve to the lowest index. Best starts at class 0, count 0.
- DONE: done_o=1 for one cycle. class_o/max_count_o are loaded on entry to DONE. Returns to IDLE.
- start_i outside IDLE is ignored and not queued.
- abort_i in any non-IDLE state: next state IDLE, no done_o, class_o/max_count_o keep their previous values. abort_i in IDLE has no effect. abort_i and start_i together in IDLE: abort wins and start is dropped.
- All-zero counts yield class 0, max_count 0.

## Timing
- Reset values: state IDLE, net_clear_o=0, net_en_o=0, in_valid_o=0, busy_o=0, done_o=0, class_o=0, max_count_o=0, internal counters 0.
- All outputs are registered or decoded from the state register only. There are no combinational paths from inputs to outputs.
- Start accepted at edge 0:
  - CLEAR occupies cycle 1.
  - RUN occupies cycles 2..W+1.
  - DRAIN occupies cycles W+2..W+D+1.
  - SCAN occupies the next NUM_CLASSES cycles.
  - done_o is high in cycle W+D+NUM_CLASSES+2.
- The earliest next start is accepted in the cycle after done_o.
- Reset asserted mid-operation forces the reset values immediately (asynchronous), and outputs stay there until release.

## Structure
- Package snn_ctrl_pkg holds:
  - the state enum;
  - the default NUM_CLASSES/COUNT_W constants shared with the spike counter;
  - a function extracting count k from the flat bus.
- One sub-module is natural: snn_argmax_scan. It holds the index counter, best register and compare, with start/step/last handshakes driven by the FSM. It is reusable for any count readout.
- The top-level wrapper instantiates this controller and ANDs the input pattern with in_valid_o.

## Test plan
- Reset: rst_i pulse mid-RUN -> all outputs 0 immediately, state IDLE after release, no done_o.
- Nominal: window_i=4, DRAIN_CYCLES=2, counts {3,7,1,0,7,2,0,0,5,6} -> net_en_o high 6 cycles, done_o 18 cycles after start edge, class_o=1 (tie with class 4 goes to lowest index), max_count_o=7.
- Window zero: window_i=0 -> RUN lasts exactly 1 cycle, done_o 15 cycles after start.
- Start while busy: second start_i during SCAN -> ignored, exactly one done_o, latched window unchanged.
- Abort: abort_i during DRAIN -> IDLE next cycle, no done_o, class_o/max_count_o retain prior result. abort_i+start_i together in IDLE -> stays IDLE.
- All-zero counts and max-value counts: all 0 -> class_o=0, max_count_o=0. Only class 9 = 255 -> class_o=9, max_count_o=255.
